tri_queue: RTL and testbench
============================

TRI_QUEUE -- requirements
Module: tri_queue

Interface
REQ-001 Parameter SIGFIG, default 24: bits per position and color field.
REQ-002 Parameter VERTS, default 3: vertices per triangle.
REQ-003 Parameter AXIS, default 3: axes per vertex (x,y,z).
REQ-004 Parameter COLORS, default 3: color channels.
REQ-005 Parameter DEPTH, default 4: triangle entries; power of two, >=2.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 tri_R10S  input  signed [SIGFIG-1:0] x [VERTS][AXIS]  upstream triangle position.
REQ-009 color_R10U  input  unsigned [SIGFIG-1:0] x [COLORS]  upstream triangle color.
REQ-010 validTri_R10H  input  1  upstream triangle valid.
REQ-011 halt_RnnnnL  output  1  to upstream; 1 = may send, 0 = halt.
REQ-012 tri_R11S  output  signed [SIGFIG-1:0] x [VERTS][AXIS]  head triangle position.
REQ-013 color_R11U  output  unsigned [SIGFIG-1:0] x [COLORS]  head triangle color.
REQ-014 validTri_R11H  output  1  head entry valid.
REQ-015 halt_dn_RnnnnL  input  1  from downstream; 1 = accepts, 0 = halted.
REQ-016 count_RnnnnU  output  $clog2(DEPTH+1)  current occupancy.
REQ-017 ovf_RnnnnH  output  1  sticky overflow flag.

Function
REQ-018 Push: validTri_R10H=1 and halt_RnnnnL=1 at a rising edge; triangle and color written at tail, tail advances.
REQ-019 Pop: validTri_R11H=1 and halt_dn_RnnnnL=1 at a rising edge; head advances.
REQ-020 halt_RnnnnL = (count_RnnnnU < DEPTH), combinational from registered count only; no dependence on halt_dn_RnnnnL.
REQ-021 validTri_R11H = (count_RnnnnU != 0); tri_R11S/color_R11U show the head entry (show-ahead) with no extra register stage.
REQ-022 Latency: push into empty queue at edge N -> validTri_R11H=1 with that data from edge N until popped (1-cycle latency).
REQ-023 Order: strict FIFO; triangles exit in arrival order, bit-exact.
REQ-024 Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH with no skipped entry.
REQ-025 Simultaneous push and pop in the same edge: count unchanged, both pointers advance; legal at any occupancy 1..DEPTH-1.
REQ-026 Full (count=DEPTH): halt_RnnnnL=0; a pop in that cycle decrements count and raises halt_RnnnnL the next cycle; no same-cycle pass-through.
REQ-027 Empty (count=0): a pop is impossible (validTri_R11H=0); outputs tri_R11S/color_R11U are don't-care but hold the last read slot.
REQ-028 validTri_R10H=1 while halt_RnnnnL=0: triangle dropped, state unchanged, ovf_RnnnnH set to 1 and held until reset.
REQ-029 Data held stable at outputs while validTri_R11H=1 and halt_dn_RnnnnL=0.

Reset
REQ-030 rst=0 asynchronously clears pointers, count_RnnnnU=0, validTri_R11H=0, ovf_RnnnnH=0, halt_RnnnnL=1 (follows from count).
REQ-031 Reset mid-operation discards all stored triangles; no entry survives; storage array need not be cleared.
REQ-032 Deassertion of rst takes effect on the first rising edge after rst=1; a push on that edge is accepted.

Verification
REQ-033 Reset, then push one triangle (vertex0 x=0x000400) with halt_dn_RnnnnL=1 -> validTri_R11H=1 one cycle later, tri_R11S[0][0]=0x000400, count 1 then 0 after pop.
REQ-034 halt_dn_RnnnnL=0, push 4 triangles -> count=4, halt_RnnnnL=0; 5th push attempt -> dropped, ovf_RnnnnH=1, head still triangle #1.
REQ-035 Full queue, halt_dn_RnnnnL=1 for one cycle -> triangle #1 popped, count=3, halt_RnnnnL=1 next cycle.
REQ-036 Continuous push and pop every cycle for 20 triangles with sequential colors 1..20 -> outputs 1..20 in order, count constant at 1, pointers wrap 5 times.
REQ-037 Queue holding 3 entries, rst pulsed low mid-cycle -> validTri_R11H=0, count=0, ovf_RnnnnH=0 immediately, without waiting for clk.
REQ-038 Random valid/halt stimulus for 10000 cycles against a reference queue model -> zero mismatches, no drop while halt_RnnnnL=1.

Source files
------------

// File: rtl/tri_queue.sv
// Show-ahead FIFO of triangles (vertex positions plus color) between pipeline stages.
// It uses ready/valid style handshakes, drops pushes when full, and keeps a sticky overflow flag.
module tri_queue #(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [SIGFIG-1:0]              tri_R10S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0]              color_R10U [COLORS],
  input  logic                                  validTri_R10H,
  output logic                                  halt_RnnnnL,
  output logic signed [SIGFIG-1:0]              tri_R11S [VERTS][AXIS],
  output logic        [SIGFIG-1:0]              color_R11U [COLORS],
  output logic                                  validTri_R11H,
  input  logic                                  halt_dn_RnnnnL,
  output logic        [$clog2(DEPTH+1)-1:0]     count_RnnnnU,
  output logic                                  ovf_RnnnnH
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic signed [SIGFIG-1:0] tri_mem   [DEPTH][VERTS][AXIS];
  logic        [SIGFIG-1:0] color_mem [DEPTH][COLORS];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] rd_slot;
  logic [CW-1:0] count;
  logic          ovf;
  logic          push;
  logic          pop;

  // Flow control depends only on registered occupancy, so full never passes through
  assign halt_RnnnnL   = (count < CW'(DEPTH));
  assign validTri_R11H = (count != '0);
  assign push          = validTri_R10H & halt_RnnnnL;
  assign pop           = validTri_R11H & halt_dn_RnnnnL;

  // When empty, keep presenting the slot that was read last
  assign rd_slot = validTri_R11H ? head : head - PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (validTri_R10H && !halt_RnnnnL) ovf <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is live
  always_ff @(posedge clk) begin
    if (push) begin
      tri_mem[tail]   <= tri_R10S;
      color_mem[tail] <= color_R10U;
    end
  end

  assign tri_R11S     = tri_mem[rd_slot];
  assign color_R11U   = color_mem[rd_slot];
  assign count_RnnnnU = count;
  assign ovf_RnnnnH   = ovf;

endmodule

// File: tb/tb_tri_queue.sv
// Directed and random checks of tri_queue against a bench-side reference queue.
// Each expected entry is queued when it is driven and compared when it reaches the head.
module tb_tri_queue;

  localparam int unsigned SIGFIG = 24;
  localparam int unsigned NV     = 3;
  localparam int unsigned NA     = 3;
  localparam int unsigned NC     = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned EW     = SIGFIG * (NV * NA + NC);
  localparam int unsigned CBASE  = SIGFIG * NV * NA;

  logic clk;
  logic rst;
  logic signed [SIGFIG-1:0] tri_in  [NV][NA];
  logic        [SIGFIG-1:0] col_in  [NC];
  logic                     vin;
  logic                     halt_up;
  logic signed [SIGFIG-1:0] tri_out [NV][NA];
  logic        [SIGFIG-1:0] col_out [NC];
  logic                     vout;
  logic                     hdn;
  logic [$clog2(DEPTH+1)-1:0] cnt;
  logic                     ovf;

  tri_queue #(.SIGFIG(SIGFIG), .VERTS(NV), .AXIS(NA), .COLORS(NC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R10S       (tri_in),
    .color_R10U     (col_in),
    .validTri_R10H  (vin),
    .halt_RnnnnL    (halt_up),
    .tri_R11S       (tri_out),
    .color_R11U     (col_out),
    .validTri_R11H  (vout),
    .halt_dn_RnnnnL (hdn),
    .count_RnnnnU   (cnt),
    .ovf_RnnnnH     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] sb_q[$];
  logic          m_ovf = 1'b0;
  logic [EW-1:0] ents [6];

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_out();
    logic [EW-1:0] r;
    r = '0;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        r[(v*3+a)*SIGFIG +: SIGFIG] = tri_out[v][a];
    for (int c = 0; c < 3; c++)
      r[CBASE + c*SIGFIG +: SIGFIG] = col_out[c];
    return r;
  endfunction

  task automatic set_in(input logic [EW-1:0] d);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        tri_in[v][a] = d[(v*3+a)*SIGFIG +: SIGFIG];
    for (int c = 0; c < 3; c++)
      col_in[c] = d[CBASE + c*SIGFIG +: SIGFIG];
  endtask

  function automatic logic [EW-1:0] rand_ent();
    logic [EW-1:0] r;
    for (int i = 0; i < 12; i++)
      r[i*SIGFIG +: SIGFIG] = SIGFIG'($urandom);
    return r;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, ".count"}, EW'(cnt), EW'(sb_q.size()));
    chk({tag, ".valid"}, EW'(vout), EW'(sb_q.size() != 0));
    chk({tag, ".halt"},  EW'(halt_up), EW'(sb_q.size() < DEPTH));
    chk({tag, ".ovf"},   EW'(ovf), EW'(m_ovf));
    if (sb_q.size() != 0) chk({tag, ".head"}, pack_out(), sb_q[0]);
  endtask

  // One clock: drive at negedge, check the registered state, then advance the model at posedge
  task automatic cycle(input string tag, input logic v, input logic [EW-1:0] d, input logic h);
    logic mpush, mpop;
    @(negedge clk);
    vin = v;
    hdn = h;
    set_in(d);
    #1;
    chk_state(tag);
    mpush = v && (sb_q.size() < DEPTH);
    mpop  = h && (sb_q.size() != 0);
    if (v && !mpush) m_ovf = 1'b1;
    @(posedge clk);
    if (mpop) void'(sb_q.pop_front());
    if (mpush) sb_q.push_back(d);
  endtask

  initial begin
    logic [EW-1:0] e;
    logic rv, rh;
    rst = 1'b0;
    vin = 1'b0;
    hdn = 1'b0;
    set_in('0);
    #1;
    chk_state("reset");
    #1 rst = 1'b1;

    // single triangle latency and pop
    e = rand_ent();
    e[SIGFIG-1:0] = 24'h000400;
    cycle("one_push", 1'b1, e, 1'b1);
    cycle("one_head", 1'b0, '0, 1'b1);
    chk("one_x", EW'(tri_out[0][0]), EW'(24'h000400));
    cycle("one_empty", 1'b0, '0, 1'b1);

    // fill while halted downstream, then overflow attempt
    for (int i = 0; i < 6; i++) ents[i] = rand_ent();
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, ents[i], 1'b0);
    cycle("full_drop", 1'b1, ents[4], 1'b0);
    cycle("full_hold", 1'b0, '0, 1'b0);
    chk("full_ovf", EW'(ovf), EW'(1'b1));
    chk("full_head", pack_out(), ents[0]);

    // one pop from full reopens the upstream side next cycle
    cycle("full_pop", 1'b0, '0, 1'b1);
    cycle("after_pop", 1'b0, '0, 1'b0);
    chk("after_pop_cnt", EW'(cnt), EW'(3));
    chk("after_pop_halt", EW'(halt_up), EW'(1'b1));
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, '0, 1'b1);

    // streaming 20 triangles with sequential colors
    for (int i = 1; i <= 20; i++) begin
      e = rand_ent();
      e[CBASE +: SIGFIG] = SIGFIG'(i);
      cycle("stream", 1'b1, e, 1'b1);
    end
    cycle("stream_tail", 1'b0, '0, 1'b1);
    cycle("stream_done", 1'b0, '0, 1'b1);

    // asynchronous reset with three entries stored and ovf still set
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, ents[i], 1'b0);
    @(negedge clk);
    vin = 1'b1;
    hdn = 1'b0;
    set_in(ents[5]);
    #1 rst = 1'b0;
    #1;
    sb_q.delete();
    m_ovf = 1'b0;
    chk_state("async_rst");
    #1 rst = 1'b1;
    @(posedge clk);
    sb_q.push_back(ents[5]);
    cycle("post_rst", 1'b0, '0, 1'b0);
    cycle("post_rst2", 1'b0, '0, 1'b1);

    // random traffic with phases biased toward full and toward empty
    for (int i = 0; i < 10000; i++) begin
      if (((i / 500) % 2) == 0) begin
        rv = ($urandom_range(0, 3) != 0);
        rh = ($urandom_range(0, 2) == 0);
      end else begin
        rv = ($urandom_range(0, 2) == 0);
        rh = ($urandom_range(0, 3) != 0);
      end
      cycle("rand", rv, rand_ent(), rh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
